// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8) helpers for the MixColumns engine.
// Optional inverse transform is built when INV_MIX_COLUMNS_EN is defined.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  localparam int         AES_NB   = 4;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } engine_state_t;

  // Multiply by x in GF(2^8), folding the overflow back with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by one of the MixColumns constants using chained xtime terms.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] res;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h2:    res = x2;
      4'h3:    res = x2 ^ b;
      4'h9:    res = x8 ^ b;
      4'hB:    res = x8 ^ x2 ^ b;
      4'hD:    res = x8 ^ x4 ^ b;
      4'hE:    res = x8 ^ x4 ^ x2;
      default: res = b;
    endcase
    return res;
  endfunction

  // Column 0 sits in the most significant 32 bits (FIPS-197 byte order).
  function automatic aes_col_t get_col(input aes_state_t s, input logic [1:0] c);
    aes_col_t col;
    case (c)
      2'd0:    col = s[127:96];
      2'd1:    col = s[95:64];
      2'd2:    col = s[63:32];
      default: col = s[31:0];
    endcase
    return col;
  endfunction

  function automatic aes_state_t set_col(input aes_state_t s, input logic [1:0] c,
                                         input aes_col_t col);
    aes_state_t r;
    r = s;
    case (c)
      2'd0:    r[127:96] = col;
      2'd1:    r[95:64]  = col;
      2'd2:    r[63:32]  = col;
      default: r[31:0]   = col;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// mix_columns_engine_if: input/output valid-ready channels of the MixColumns engine.
// The engine uses the slave modport; the producer/consumer side uses master.
interface mix_columns_engine_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

endinterface

// File: rtl/mix_column_unit.sv
// mix_column_unit: combinational MixColumns / InvMixColumns of a single 32-bit column.
// The inverse matrix is only built when INV_MIX_COLUMNS_EN is defined; otherwise both
// selections produce the forward result and the select collapses away.
module mix_column_unit
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);

  logic [7:0] a0, a1, a2, a3;
  aes_col_t   fwd_col;
  aes_col_t   inv_col;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Forward matrix rows 02 03 01 01, rotated one position per row.
  always_comb begin
    fwd_col[31:24] = gf_mul_const(a0, 4'h2) ^ gf_mul_const(a1, 4'h3) ^ a2 ^ a3;
    fwd_col[23:16] = a0 ^ gf_mul_const(a1, 4'h2) ^ gf_mul_const(a2, 4'h3) ^ a3;
    fwd_col[15:8]  = a0 ^ a1 ^ gf_mul_const(a2, 4'h2) ^ gf_mul_const(a3, 4'h3);
    fwd_col[7:0]   = gf_mul_const(a0, 4'h3) ^ a1 ^ a2 ^ gf_mul_const(a3, 4'h2);
  end

`ifdef INV_MIX_COLUMNS_EN
  // Inverse matrix rows 0E 0B 0D 09, rotated one position per row.
  always_comb begin
    inv_col[31:24] = gf_mul_const(a0, 4'hE) ^ gf_mul_const(a1, 4'hB) ^
                     gf_mul_const(a2, 4'hD) ^ gf_mul_const(a3, 4'h9);
    inv_col[23:16] = gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'hE) ^
                     gf_mul_const(a2, 4'hB) ^ gf_mul_const(a3, 4'hD);
    inv_col[15:8]  = gf_mul_const(a0, 4'hD) ^ gf_mul_const(a1, 4'h9) ^
                     gf_mul_const(a2, 4'hE) ^ gf_mul_const(a3, 4'hB);
    inv_col[7:0]   = gf_mul_const(a0, 4'hB) ^ gf_mul_const(a1, 4'hD) ^
                     gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'hE);
  end
`else
  assign inv_col = fwd_col;
`endif

  assign col_o = inv_i ? inv_col : fwd_col;

endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: sequential MixColumns stage, COLS_PER_CYCLE columns per clock,
// valid/ready in, registered back-pressurable out.
// Define INV_MIX_COLUMNS_EN to honour in_inv (InvMixColumns); otherwise in_inv is ignored.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mix_columns_engine_if.slave   bus,
  output logic                  busy
);

  localparam int NUM_STEPS = AES_NB / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  engine_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  aes_state_t    work_q, work_d;
  aes_state_t    result_q, result_d;
  logic          inv_q, inv_d;
  logic          live_q;
  logic          accept;
  logic          last_step;

  aes_col_t      lane_in  [COLS_PER_CYCLE];
  aes_col_t      lane_out [COLS_PER_CYCLE];
  logic [1:0]    lane_idx [COLS_PER_CYCLE];

  assign last_step = (cnt_q == 2'(NUM_STEPS - 1));

  // Pick the columns handled this step: cnt*COLS_PER_CYCLE upward.
  always_comb begin
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      lane_idx[l] = 2'(int'(cnt_q) * COLS_PER_CYCLE + l);
      lane_in[l]  = get_col(work_q, lane_idx[l]);
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    mix_column_unit u_unit (
      .col_i (lane_in[g]),
      .inv_i (inv_q),
      .col_o (lane_out[g])
    );
  end

  // Next-state, handshake outputs and datapath updates for IDLE/BUSY/DONE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    work_d        = work_q;
    result_d      = result_q;
    inv_d         = inv_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.in_ready = live_q;
        accept       = live_q && bus.in_valid;
      end
      ST_BUSY: begin
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
          result_d = set_col(result_d, lane_idx[l], lane_out[l]);
        end
        if (last_step) begin
          state_d = ST_DONE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      work_d  = bus.in_state;
`ifdef INV_MIX_COLUMNS_EN
      inv_d   = bus.in_inv;
`else
      inv_d   = 1'b0;
`endif
      cnt_d   = 2'd0;
      state_d = ST_BUSY;
    end
  end

  // State and datapath registers; live_q holds off in_ready until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      work_q   <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      inv_q    <= inv_d;
      live_q   <= 1'b1;
    end
  end

  assign bus.out_state = result_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
